// File: rtl/iter_shift_unit.sv
// Multi-cycle shift unit: shifts the latched operand one bit per cycle and returns
// the result with its rd tag over a valid/ready handshake.
module iter_shift_unit #(
    parameter int XLEN  = 32,
    parameter int SHW   = 5,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_a,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_stype,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_r,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0]     ST_SRL  = 2'b00;
    localparam logic [1:0]     ST_SLL  = 2'b01;
    localparam logic [1:0]     ST_SRA  = 2'b10;
    localparam logic [1:0]     ST_PASS = 2'b11;
    localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [XLEN-1:0]  r_q, r_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [1:0]       stype_q, stype_d;

    function automatic logic [XLEN-1:0] shift_step(input logic [XLEN-1:0] v,
                                                   input logic [1:0]      st);
        logic [XLEN-1:0] res;
        case (st)
            ST_SRL:  res = {1'b0, v[XLEN-1:1]};
            ST_SLL:  res = {v[XLEN-2:0], 1'b0};
            ST_SRA:  res = {v[XLEN-1], v[XLEN-1:1]};
            default: res = v;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            tag_q   <= '0;
            cnt_q   <= '0;
            stype_q <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            stype_q <= stype_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        stype_d = stype_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    r_d     = in_a;
                    tag_d   = in_tag;
                    stype_d = in_stype;
                    cnt_d   = in_shamt;
                    if (in_stype == ST_PASS || in_shamt == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                r_d   = shift_step(r_q, stype_q);
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Flush wins over every other transition, including a DONE handshake.
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_r     = r_q;
    assign out_tag   = tag_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Self-checking bench for iter_shift_unit: directed cases then a random scoreboard.
module tb_iter_shift_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [4:0]  in_shamt;
    logic [1:0]  in_stype;
    logic [4:0]  in_tag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_r;
    logic [4:0]  out_tag;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    iter_shift_unit #(.XLEN(32), .SHW(5), .TAG_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_shamt  (in_shamt),
        .in_stype  (in_stype),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] sh,
                                              input logic [1:0] st);
        logic signed [31:0] sa;
        sa = a;
        case (st)
            2'b00:   return a >> sh;
            2'b01:   return a << sh;
            2'b10:   return $unsigned(sa >>> sh);
            default: return a;
        endcase
    endfunction

    task automatic flush_pulse();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    // One request end to end; lat counts clock edges after the accept edge.
    task automatic run_req(input logic [31:0] a, input logic [4:0] sh, input logic [1:0] st,
                           input logic [4:0] tg, input int stall, input bit hold_ready,
                           input bit full, input string nm);
        logic [31:0] exp_r;
        int          exp_lat;
        int          lat;
        int          busy_cnt;
        exp_r   = ref_shift(a, sh, st);
        exp_lat = (st == 2'b11 || sh == 5'd0) ? 0 : int'(sh);
        @(negedge clk);
        check({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_a      = a;
        in_shamt  = sh;
        in_stype  = st;
        in_tag    = tg;
        out_ready = hold_ready;
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = $urandom;
        in_shamt = 5'($urandom);
        in_stype = 2'($urandom);
        in_tag   = 5'($urandom);
        lat      = 0;
        busy_cnt = 0;
        while (!out_valid && lat < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        check({nm, "_latency"}, lat, exp_lat);
        check({nm, "_out_r"}, out_r, exp_r);
        check({nm, "_out_tag"}, {27'd0, out_tag}, {27'd0, tg});
        if (!out_valid) begin
            out_ready = 1'b0;
            flush_pulse();
            return;
        end
        if (busy) busy_cnt++;
        if (hold_ready) begin
            if (full) check({nm, "_busy_cycles"}, busy_cnt, exp_lat + 1);
            @(negedge clk);
            check({nm, "_drop_valid"}, {31'd0, out_valid}, 32'd0);
        end else begin
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                if (full) begin
                    check({nm, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
                    check({nm, "_stall_r"}, out_r, exp_r);
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check({nm, "_idle_after"}, {30'd0, busy, out_valid}, 32'd0);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        int k;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_shamt  = '0;
        in_stype  = '0;
        in_tag    = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        rst = 1'b0;

        // Reset then idle.
        repeat (5) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out_r", out_r, 32'd0);
        check("rst_out_tag", {27'd0, out_tag}, 32'd0);

        // Directed cases.
        run_req(32'h8000_0010, 5'd4, 2'b10, 5'd9, 0, 1'b1, 1'b1, "sra4");
        check("sra4_value", ref_shift(32'h8000_0010, 5'd4, 2'b10), 32'hF800_0001);
        run_req(32'h0000_0001, 5'd31, 2'b01, 5'd3, 3, 1'b0, 1'b1, "sll31");
        run_req(32'hFFFF_FFFF, 5'd31, 2'b00, 5'd17, 3, 1'b0, 1'b1, "srl31");
        run_req(32'hDEAD_BEEF, 5'd0, 2'b01, 5'd1, 1, 1'b0, 1'b1, "sll0");
        run_req(32'hCAFE_F00D, 5'd7, 2'b11, 5'd30, 0, 1'b1, 1'b1, "pass7");
        run_req(32'h8000_0000, 5'd31, 2'b10, 5'd31, 0, 1'b1, 1'b1, "sra31");

        // Flush during SHIFT: no result ever appears.
        @(negedge clk);
        in_valid = 1'b1; in_a = 32'hFFFF_0000; in_shamt = 5'd10; in_stype = 2'b00; in_tag = 5'd5;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_shift_idle", {30'd0, busy, in_ready}, 32'd1);
        k = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) k++;
        end
        check("flush_shift_no_valid", k, 0);
        run_req(32'h1234_5678, 5'd8, 2'b00, 5'd12, 0, 1'b1, 1'b1, "after_flush");

        // Flush with in_valid in IDLE blocks acceptance.
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; in_a = 32'h5; in_shamt = 5'd2; in_stype = 2'b01;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_idle_block", {30'd0, busy, out_valid}, 32'd0);

        // Flush beats out_ready in DONE.
        @(negedge clk);
        in_valid = 1'b1; in_a = 32'h0000_00F0; in_shamt = 5'd2; in_stype = 2'b00; in_tag = 5'd7;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("flush_done_reached", {31'd0, out_valid}, 32'd1);
        check("flush_done_r", out_r, 32'h0000_003C);
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b0;
        check("flush_done_drop", {30'd0, busy, out_valid}, 32'd0);

        // Asynchronous reset between edges during SHIFT.
        @(negedge clk);
        in_valid = 1'b1; in_a = 32'hA5A5_A5A5; in_shamt = 5'd20; in_stype = 2'b10; in_tag = 5'd21;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ctrl", {29'd0, in_ready, out_valid, busy}, 32'd4);
        check("arst_out_r", out_r, 32'd0);
        check("arst_out_tag", {27'd0, out_tag}, 32'd0);
        #1;
        rst = 1'b0;
        k = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) k++;
        end
        check("arst_no_valid", k, 0);
        run_req(32'h8765_4321, 5'd13, 2'b01, 5'd4, 1, 1'b0, 1'b1, "after_arst");

        // Random scoreboard.
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] ra;
            logic [4:0]  rs;
            logic [1:0]  rt;
            logic [4:0]  rg;
            bit          hr;
            ra = $urandom;
            rs = 5'($urandom);
            rt = 2'($urandom);
            rg = 5'($urandom);
            hr = 1'($urandom_range(0, 1));
            run_req(ra, rs, rt, rg, hr ? 0 : int'($urandom_range(0, 2)), hr, 1'b0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
